// File: rtl/cpu_clk_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_clk_ctrl_pkg
//   Shared definitions for the CPU clock-domain sequencer: FSM state encoding
//   and ce_count width. The board debug/LED readout decodes the 3-bit state
//   output using these same encodings, so they must stay stable.
// ---------------------------------------------------------------------------
package cpu_clk_ctrl_pkg;

  // Width of the enabled-cycle counter exported to the CPU debug logic.
  localparam int CE_COUNT_W = 32;

  // Sequencer states. The numeric values are visible on the state output.
  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,  // waiting for the clocking wizard to lock
    ST_RST_HOLD  = 3'd1,  // locked; holding the CPU in reset for a fixed count
    ST_HALT      = 3'd2,  // CPU out of reset, clock-enable parked low
    ST_RUN       = 3'd3,  // free-running at the divided rate
    ST_STEP      = 3'd4   // waiting for one divided tick, then back to HALT
  } state_t;

  // The CPU is out of reset in every state past the reset hold.
  function automatic logic cpu_released(input state_t s);
    return (s == ST_HALT) || (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/cpu_clk_ctrl_divider.sv
// ---------------------------------------------------------------------------
// clk_en_divider
//   Rate divider for the CPU clock-enable. Produces a tick once every
//   div_sel+1 cycles measured from the last clear.
//
//   Ports
//     clk      in  1      sequencer clock
//     rst_n    in  1      async active-low reset
//     clr      in  1      restart the period (entry into RUN or STEP)
//     div_sel  in  DIV_W  period minus one; live, not registered
//     tick     out 1      high in the last cycle of each period
// ---------------------------------------------------------------------------
module clk_en_divider
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_sel,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  // '>=' rather than '==' so that shrinking div_sel below the current count
  // fires immediately instead of waiting for the counter to wrap.
  assign tick = (cnt_q >= div_sel);

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its neighbours, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_clk_ctrl
//   Sequences the CPU clock domain fed by the cpuclk wizard (clk_out1 and
//   locked). After lock it holds the CPU in reset for RST_CYCLES cycles, then
//   gates execution through a clock-enable in RUN, HALT or single STEP mode,
//   optionally slowed by a rate divider.
//
//   Parameters
//     RST_CYCLES    cycles cpu_rst_n is held low after lock (>= 1)
//     DIV_W         width of div_sel
//     START_HALTED  1: leave reset into HALT, 0: into RUN
//
//   Ports
//     clk        in  1      wizard clk_out1, sole clock
//     rst_n      in  1      async active-low reset
//     locked     in  1      wizard lock, already in the clk domain
//     run_req    in  1      pulse: enter RUN
//     halt_req   in  1      pulse: enter HALT (highest priority)
//     step_req   in  1      pulse: execute one enabled cycle
//     div_sel    in  DIV_W  cpu_ce period = div_sel+1 cycles
//     cpu_rst_n  out 1      registered CPU reset, active low
//     cpu_ce     out 1      registered CPU clock-enable
//     state      out 3      current sequencer state (see package)
//     ce_count   out 32     cpu_ce cycles since the CPU left reset
// ---------------------------------------------------------------------------
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int DIV_W        = 8,
  parameter bit START_HALTED = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  locked,
  input  logic                  run_req,
  input  logic                  halt_req,
  input  logic                  step_req,
  input  logic [DIV_W-1:0]      div_sel,
  output logic                  cpu_rst_n,
  output logic                  cpu_ce,
  output logic [2:0]            state,
  output logic [CE_COUNT_W-1:0] ce_count
);

  // Hold counter only has to reach RST_CYCLES-1.
  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic [HOLD_W-1:0]       hold_cnt_q;
  logic                    hold_done;
  logic                    tick;
  logic                    div_clr;
  logic                    cpu_rst_n_d;
  logic                    cpu_ce_d;
  logic [CE_COUNT_W-1:0]   ce_count_q;

  // -------------------------------------------------------------------------
  // Rate divider
  // -------------------------------------------------------------------------
  clk_en_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (div_clr),
    .div_sel (div_sel),
    .tick    (tick)
  );

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_LOCK;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  assign hold_done = (hold_cnt_q == HOLD_LAST);

  // NOTE: every variable driven here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (!locked) begin
      // Losing lock overrides everything, including pending requests.
      state_d = ST_WAIT_LOCK;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: state_d = ST_RST_HOLD;
        ST_RST_HOLD: begin
          if (hold_done) state_d = START_HALTED ? ST_HALT : ST_RUN;
        end
        ST_HALT: begin
          // halt_req > run_req > step_req; halt_req here is a no-op that
          // still suppresses the lower-priority requests.
          if (halt_req)      state_d = ST_HALT;
          else if (run_req)  state_d = ST_RUN;
          else if (step_req) state_d = ST_STEP;
        end
        ST_RUN: begin
          if (halt_req) state_d = ST_HALT;
        end
        ST_STEP: begin
          // Either the single enabled cycle is issued or it is cancelled.
          if (halt_req || tick) state_d = ST_HALT;
        end
        default: state_d = ST_WAIT_LOCK;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output logic (next values of the registered outputs)
  // -------------------------------------------------------------------------
  always_comb begin
    cpu_rst_n_d = cpu_released(state_d);
    cpu_ce_d    = 1'b0;
    // Restart the divider period on each entry so the first enable lands
    // exactly div_sel+1 cycles after the state change.
    div_clr     = ((state_d == ST_RUN)  && (state_q != ST_RUN)) ||
                  ((state_d == ST_STEP) && (state_q != ST_STEP));
    unique case (state_q)
      // Staying in RUN is required: a halt or lock loss on a tick wins.
      ST_RUN:  cpu_ce_d = tick && (state_d == ST_RUN);
      // Leaving STEP for HALT without a halt request means the tick fired.
      ST_STEP: cpu_ce_d = tick && (state_d == ST_HALT) && !halt_req;
      default: cpu_ce_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rst_n <= 1'b0;
      cpu_ce    <= 1'b0;
    end else begin
      cpu_rst_n <= cpu_rst_n_d;
      cpu_ce    <= cpu_ce_d;
    end
  end

  // -------------------------------------------------------------------------
  // Reset hold counter: counts cycles spent in RST_HOLD, zero elsewhere.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else if (state_q != ST_RST_HOLD) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Enabled-cycle counter. Cleared on the same edge cpu_rst_n falls so the
  // count is already zero in the first cycle the CPU sees reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_count_q <= '0;
    end else if (!cpu_rst_n_d) begin
      ce_count_q <= '0;
    end else if (cpu_ce) begin
      ce_count_q <= ce_count_q + CE_COUNT_W'(1);
    end
  end

  assign ce_count = ce_count_q;
  assign state    = state_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_clk_ctrl
//   Scoreboard bench for cpu_clk_ctrl. Each driven cycle runs a behavioural
//   model of the sequencer and queues the outputs expected after the next
//   clock edge; an independent monitor pops and compares after every edge.
// ---------------------------------------------------------------------------
module tb_cpu_clk_ctrl;

  localparam int RST_CYCLES = 16;
  localparam int DIV_W      = 8;

  // Model state numbering (values visible on the state output).
  localparam int S_WAIT = 0;
  localparam int S_HOLD = 1;
  localparam int S_HALT = 2;
  localparam int S_RUN  = 3;
  localparam int S_STEP = 4;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             locked   = 1'b0;
  logic             run_req  = 1'b0;
  logic             halt_req = 1'b0;
  logic             step_req = 1'b0;
  logic [DIV_W-1:0] div_sel  = '0;
  logic             cpu_rst_n;
  logic             cpu_ce;
  logic [2:0]       state;
  logic [31:0]      ce_count;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .DIV_W        (DIV_W),
    .START_HALTED (1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .locked    (locked),
    .run_req   (run_req),
    .halt_req  (halt_req),
    .step_req  (step_req),
    .div_sel   (div_sel),
    .cpu_rst_n (cpu_rst_n),
    .cpu_ce    (cpu_ce),
    .state     (state),
    .ce_count  (ce_count)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        rst_n;
    logic        ce;
    logic [31:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: sequencer behaviour in plain integers.
  // -------------------------------------------------------------------------
  int          m_st    = S_WAIT;
  int          m_held  = 0;   // cycles already spent holding reset
  int          m_phase = 0;   // cycles since the divider period restarted
  logic        m_ce    = 1'b0;
  logic [31:0] m_cnt   = '0;

  // Drive one cycle of inputs, predict the outputs after the coming edge,
  // then wait for the falling edge.
  task automatic cyc(input logic lk, input logic rr, input logic hr, input logic sr);
    int   ns;
    bit   tick;
    bit   ce_n;
    logic rel;
    locked   = lk;
    run_req  = rr;
    halt_req = hr;
    step_req = sr;
    if (!rst_n) begin
      m_st = S_WAIT; m_held = 0; m_phase = 0; m_ce = 1'b0; m_cnt = '0;
      rel  = 1'b0;
    end else begin
      tick = (m_phase >= int'(div_sel));
      ns   = m_st;
      ce_n = 1'b0;
      if (!lk) ns = S_WAIT;
      else begin
        case (m_st)
          S_WAIT: begin ns = S_HOLD; m_held = 0; end
          S_HOLD: begin
            m_held++;
            if (m_held == RST_CYCLES) ns = S_RUN;
          end
          S_HALT: begin
            if (hr)      ns = S_HALT;
            else if (rr) ns = S_RUN;
            else if (sr) ns = S_STEP;
          end
          S_RUN: begin
            if (hr)        ns = S_HALT;
            else if (tick) ce_n = 1'b1;
          end
          S_STEP: begin
            if (hr) ns = S_HALT;
            else if (tick) begin ce_n = 1'b1; ns = S_HALT; end
          end
          default: ns = S_WAIT;
        endcase
      end
      if ((ns == S_RUN && m_st != S_RUN) || (ns == S_STEP && m_st != S_STEP) || tick)
        m_phase = 0;
      else
        m_phase++;
      rel = (ns == S_HALT) || (ns == S_RUN) || (ns == S_STEP);
      if (!rel)      m_cnt = '0;
      else if (m_ce) m_cnt = m_cnt + 32'd1;
      m_ce = ce_n;
      m_st = ns;
    end
    exp_q.push_back('{st: 3'(m_st), rst_n: rel, ce: m_ce, cnt: m_cnt});
    @(negedge clk);
  endtask

  // -------------------------------------------------------------------------
  // Monitor: one observation per clock edge, compared against the queue.
  // -------------------------------------------------------------------------
  always @(posedge clk) begin
    obs_t e;
    obs_t a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{st: state, rst_n: cpu_rst_n, ce: cpu_ce, cnt: ce_count};
      check("state/cpu_rst_n/cpu_ce/ce_count", 64'(a), 64'(e));
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic [31:0] c0;
    logic        lk;
    int          r;

    // Held in reset with no lock.
    rst_n = 1'b0;
    repeat (20) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Lock, full reset hold, then RUN with an enable every cycle.
    div_sel = 8'd0;
    repeat (30) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // RUN at 1-of-4; 40 steady-state cycles must add exactly 10.
    div_sel = 8'd3;
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    c0 = ce_count;
    repeat (40) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("ce_count_delta_40_cycles", 64'(ce_count - c0), 64'd10);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // Single step at div_sel=2, then simultaneous run+halt in HALT.
    div_sel = 8'd2;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    // Step cancelled by halt before its tick.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // RUN, shrink div_sel mid-count, then a one-cycle lock loss.
    div_sel = 8'd6;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    div_sel = 8'd1;
    repeat (8) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (25) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // ce_count wrap: preload near all-ones while enabled every cycle.
    div_sel = 8'd0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    force dut.ce_count_q = 32'hFFFF_FFFD;
    #1;
    release dut.ce_count_q;
    m_cnt = 32'hFFFF_FFFD;
    repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of RUN.
    rst_n = 1'b0;
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic: requests, rate changes, rare lock loss.
    for (int i = 0; i < 3000; i++) begin
      lk = ($urandom_range(0, 299) != 0);
      r  = int'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) div_sel = DIV_W'($urandom_range(0, 6));
      cyc(lk, (r == 0) || (r == 3), (r == 1) || (r == 3), (r == 2) || (r == 4));
    end

    repeat (2) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
